// File: rtl/wd_pkg.sv
// -----------------------------------------------------------------------------
// wd_pkg
// Shared definitions for the watchdog supervisor slice.
//   - state_t        : supervisor FSM state encoding (visible on the state port)
//   - RETRY_W        : width of the saturating trip counter
//   - DEF_*          : default parameter values used by wd_supervisor and
//                      wd_kick_collector
//   - retry_inc()    : saturating increment for the trip counter
// -----------------------------------------------------------------------------
package wd_pkg;

   localparam int unsigned RETRY_W = 2;

   localparam int unsigned      DEF_N_SRC         = 3;
   localparam logic [2:0]       DEF_SRC_MASK      = 3'b111;
   localparam int unsigned      DEF_RST_HOLD      = 16;
   localparam int unsigned      DEF_UNMUTE_DELAY  = 8;
   localparam int unsigned      DEF_MAX_RETRY     = 3;
   localparam int unsigned      DEF_STABLE_CYCLES = 1024;
   localparam int unsigned      DEF_CNT_W         = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STARTUP = 3'd1,
      ST_RUN     = 3'd2,
      ST_RECOVER = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   // Saturates at all-ones so repeated trips never wrap back to zero.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
      logic [RETRY_W-1:0] res;
      res = (&cnt) ? cnt : cnt + 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/wd_kick_collector.sv
// -----------------------------------------------------------------------------
// wd_kick_collector
// Gathers kick pulses from N_SRC requesters and emits one heartbeat pulse once
// every enabled source has kicked in the current round.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   active     in   high while the supervisor stays in RUN; low clears the round
//   src_kick   in   per-source kick pulses
//   heartbeat  out  one-cycle pulse, registered, the cycle after a round completes
// -----------------------------------------------------------------------------
module wd_kick_collector
   import wd_pkg::*;
#(
   parameter int unsigned          N_SRC    = DEF_N_SRC,
   parameter logic [N_SRC-1:0]     SRC_MASK = DEF_SRC_MASK
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [N_SRC-1:0]  src_kick,
   output logic              heartbeat
);

   logic [N_SRC-1:0] kick_seen;
   logic [N_SRC-1:0] kick_acc;
   logic             round_done;

   // Masked-off sources are treated as having kicked already.
   always_comb begin
      kick_acc   = kick_seen | src_kick | ~SRC_MASK;
      round_done = &kick_acc;
   end

   // A completing round clears kick_seen outright, so kicks arriving in the
   // completing cycle are consumed rather than carried into the next round.
   always_ff @(posedge clk) begin
      if (rst || !active) begin
         kick_seen <= '0;
         heartbeat <= 1'b0;
      end else if (round_done) begin
         kick_seen <= '0;
         heartbeat <= 1'b1;
      end else begin
         kick_seen <= kick_acc;
         heartbeat <= 1'b0;
      end
   end

endmodule

// File: rtl/wd_supervisor.sv
// -----------------------------------------------------------------------------
// wd_supervisor
// Sequencer and heartbeat scheduler in front of watchdog_timer. Owns the
// watchdog enable, the radio datapath reset and the audio mute, runs a bounded
// recovery after each watchdog trip and locks out after too many trips.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   arm            in   level; request supervised operation
//   src_kick       in   per-source kick pulses
//   clear_fault    in   pulse; leave LOCKOUT
//   wd_trip        in   force_reset from watchdog_timer (honoured in RUN only)
//   wd_enable      out  enable to watchdog_timer
//   wd_heartbeat   out  one-cycle heartbeat to watchdog_timer
//   sys_rst        out  active-high reset to radio datapath
//   audio_mute     out  DAC/audio mute
//   fault_latched  out  high in LOCKOUT
//   retry_count    out  trips since last stable period, saturating
//   state          out  current FSM state encoding
// All outputs are registered; their next values are derived from the next
// state and next timer value so they change on the same edge as the state.
// -----------------------------------------------------------------------------
module wd_supervisor
   import wd_pkg::*;
#(
   parameter int unsigned          N_SRC         = DEF_N_SRC,
   parameter logic [N_SRC-1:0]     SRC_MASK      = DEF_SRC_MASK,
   parameter int unsigned          RST_HOLD      = DEF_RST_HOLD,
   parameter int unsigned          UNMUTE_DELAY  = DEF_UNMUTE_DELAY,
   parameter int unsigned          MAX_RETRY     = DEF_MAX_RETRY,
   parameter int unsigned          STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned          CNT_W         = DEF_CNT_W
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                arm,
   input  logic [N_SRC-1:0]    src_kick,
   input  logic                clear_fault,
   input  logic                wd_trip,
   output logic                wd_enable,
   output logic                wd_heartbeat,
   output logic                sys_rst,
   output logic                audio_mute,
   output logic                fault_latched,
   output logic [RETRY_W-1:0]  retry_count,
   output logic [2:0]          state
);

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] UNMUTE_LIM = CNT_W'(UNMUTE_DELAY);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic                abort_q, abort_d;

   logic                hold_done;
   logic                retry_exhausted;
   logic                abort_now;
   logic                collect_active;

   logic                wd_enable_d;
   logic                sys_rst_d;
   logic                audio_mute_d;
   logic                fault_latched_d;

   assign hold_done       = (timer_q == HOLD_LAST);
   assign retry_exhausted = (32'(retry_q) >= MAX_RETRY);
   // arm dropped at any point since the trip, including the current cycle.
   assign abort_now       = abort_q | ~arm;

   // --------------------------------------------------------------------------
   // State register (with the timer, trip counter and the output registers)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         retry_q       <= '0;
         abort_q       <= 1'b0;
         wd_enable     <= 1'b0;
         sys_rst       <= 1'b1;
         audio_mute    <= 1'b1;
         fault_latched <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         abort_q       <= abort_d;
         wd_enable     <= wd_enable_d;
         sys_rst       <= sys_rst_d;
         audio_mute    <= audio_mute_d;
         fault_latched <= fault_latched_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arm) state_d = ST_STARTUP;
         end
         ST_STARTUP: begin
            if (!arm)          state_d = ST_IDLE;
            else if (hold_done) state_d = ST_RUN;
         end
         ST_RUN: begin
            // A trip outranks a simultaneous disarm.
            if (wd_trip)   state_d = ST_RECOVER;
            else if (!arm) state_d = ST_IDLE;
         end
         ST_RECOVER: begin
            if (hold_done) begin
               if (retry_exhausted) state_d = ST_LOCKOUT;
               else if (abort_now)  state_d = ST_IDLE;
               else                 state_d = ST_RUN;
            end
         end
         ST_LOCKOUT: begin
            if (clear_fault) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Timer, trip counter and disarm tracking
   // One timer serves as hold counter in STARTUP/RECOVER and as the RUN age
   // (unmute delay and stability period); it restarts on every state change.
   // --------------------------------------------------------------------------
   always_comb begin
      timer_d = '0;
      if (state_d == state_q) begin
         unique case (state_q)
            ST_STARTUP, ST_RECOVER: timer_d = timer_q + 1'b1;
            ST_RUN:                 timer_d = (timer_q == STABLE_LIM) ? timer_q
                                                                      : timer_q + 1'b1;
            default:                timer_d = '0;
         endcase
      end
   end

   always_comb begin
      retry_d = retry_q;
      if (state_q == ST_RUN && wd_trip)
         retry_d = retry_inc(retry_q);
      else if (state_q == ST_RUN && state_d == ST_RUN && timer_d == STABLE_LIM)
         retry_d = '0;
      else if (state_q == ST_LOCKOUT && clear_fault)
         retry_d = '0;
   end

   always_comb begin
      abort_d = 1'b0;
      if (state_q == ST_RUN && state_d == ST_RECOVER)
         abort_d = ~arm;
      else if (state_q == ST_RECOVER)
         abort_d = abort_now;
   end

   // --------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // --------------------------------------------------------------------------
   always_comb begin
      wd_enable_d     = (state_d == ST_RUN);
      sys_rst_d       = (state_d != ST_RUN);
      audio_mute_d    = (state_d != ST_RUN) || (timer_d < UNMUTE_LIM);
      fault_latched_d = (state_d == ST_LOCKOUT);
   end

   assign retry_count = retry_q;
   assign state       = state_q;

   // Collection only proceeds while RUN is held; leaving RUN (trip or disarm)
   // drops the round and suppresses a heartbeat completing on that edge.
   assign collect_active = (state_q == ST_RUN) && (state_d == ST_RUN);

   wd_kick_collector #(
      .N_SRC    (N_SRC),
      .SRC_MASK (SRC_MASK)
   ) u_kick_collector (
      .clk       (clk),
      .rst       (rst),
      .active    (collect_active),
      .src_kick  (src_kick),
      .heartbeat (wd_heartbeat)
   );

endmodule

// File: tb/tb_wd_supervisor.sv
// -----------------------------------------------------------------------------
// tb_wd_supervisor
// Two supervisors share one stimulus stream: dut_a with all sources enabled,
// dut_b with source 2 masked off. A behavioural reference predicts every
// output of both after each clock edge.
// -----------------------------------------------------------------------------
module tb_wd_supervisor;

   localparam int RST_HOLD  = 16;
   localparam int UNMUTE    = 8;
   localparam int MAX_RETRY = 3;
   localparam int STABLE    = 1024;

   localparam int PH_IDLE = 0, PH_STARTUP = 1, PH_RUN = 2, PH_RECOVER = 3, PH_LOCKOUT = 4;

   logic       clk = 1'b0;
   logic       rst, arm, clear_fault, wd_trip;
   logic [2:0] src_kick;

   logic       a_en, a_hb, a_srst, a_mute, a_flt;
   logic [1:0] a_rc;
   logic [2:0] a_st;
   logic       b_en, b_hb, b_srst, b_mute, b_flt;
   logic [1:0] b_rc;
   logic [2:0] b_st;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   wd_supervisor dut_a (
      .clk(clk), .rst(rst), .arm(arm), .src_kick(src_kick),
      .clear_fault(clear_fault), .wd_trip(wd_trip),
      .wd_enable(a_en), .wd_heartbeat(a_hb), .sys_rst(a_srst),
      .audio_mute(a_mute), .fault_latched(a_flt),
      .retry_count(a_rc), .state(a_st)
   );

   wd_supervisor #(.SRC_MASK(3'b011)) dut_b (
      .clk(clk), .rst(rst), .arm(arm), .src_kick(src_kick),
      .clear_fault(clear_fault), .wd_trip(wd_trip),
      .wd_enable(b_en), .wd_heartbeat(b_hb), .sys_rst(b_srst),
      .audio_mute(b_mute), .fault_latched(b_flt),
      .retry_count(b_rc), .state(b_st)
   );

   // Reference: phase, cycles spent in the phase, trips, set of sources
   // already heard from this round, whether arm fell during recovery,
   // and whether a heartbeat is due.
   typedef struct {
      int      phase;
      int      age;
      int      trips;
      bit [2:0] heard;
      bit      disarmed;
      bit      beat;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.phase = PH_IDLE; r.age = 0; r.trips = 0;
      r.heard = 3'b000; r.disarmed = 1'b0; r.beat = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, bit r, bit a, bit [2:0] k,
                                     bit c, bit t, bit [2:0] enabled);
      mdl_t n;
      bit   all_in;
      if (r) return mdl_reset();
      n = m;
      n.beat = 1'b0;
      case (m.phase)
         PH_IDLE: if (a) begin n.phase = PH_STARTUP; n.age = 0; end
         PH_STARTUP: begin
            if (!a) n.phase = PH_IDLE;
            else if (m.age == RST_HOLD - 1) begin n.phase = PH_RUN; n.age = 0; end
            else n.age = m.age + 1;
         end
         PH_RUN: begin
            if (t) begin
               n.phase = PH_RECOVER; n.age = 0; n.heard = 3'b000;
               n.trips = (m.trips < 3) ? m.trips + 1 : 3;
               n.disarmed = !a;
            end else if (!a) begin
               n.phase = PH_IDLE; n.heard = 3'b000;
            end else begin
               all_in = 1'b1;
               for (int s = 0; s < 3; s++)
                  if (enabled[s] && !(m.heard[s] || k[s])) all_in = 1'b0;
               if (all_in) begin n.beat = 1'b1; n.heard = 3'b000; end
               else n.heard = m.heard | k;
               n.age = (m.age < STABLE) ? m.age + 1 : STABLE;
               if (n.age == STABLE) n.trips = 0;
            end
         end
         PH_RECOVER: begin
            n.disarmed = m.disarmed || !a;
            if (m.age == RST_HOLD - 1) begin
               n.age = 0;
               if (m.trips >= MAX_RETRY) n.phase = PH_LOCKOUT;
               else if (n.disarmed)     n.phase = PH_IDLE;
               else                     n.phase = PH_RUN;
            end else n.age = m.age + 1;
         end
         PH_LOCKOUT: if (c) begin n.phase = PH_IDLE; n.trips = 0; end
         default: n = mdl_reset();
      endcase
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string who, input mdl_t m,
                                input logic [2:0] st, input logic [1:0] rc,
                                input logic en, input logic hb, input logic srst,
                                input logic mute, input logic flt);
      bit running;
      running = (m.phase == PH_RUN);
      check({who, ".state"},         32'(st),   32'(m.phase));
      check({who, ".retry_count"},   32'(rc),   32'(m.trips));
      check({who, ".wd_enable"},     32'(en),   32'(running));
      check({who, ".wd_heartbeat"},  32'(hb),   32'(m.beat));
      check({who, ".sys_rst"},       32'(srst), 32'(!running));
      check({who, ".audio_mute"},    32'(mute), 32'(!running || m.age < UNMUTE));
      check({who, ".fault_latched"}, 32'(flt),  32'(m.phase == PH_LOCKOUT));
   endtask

   // Check what the last edge produced, then drive the next inputs and
   // advance the reference across the coming edge.
   task automatic cyc(input bit r, input bit a, input bit [2:0] k, input bit c, input bit t);
      @(negedge clk);
      check_outputs("A", ma, a_st, a_rc, a_en, a_hb, a_srst, a_mute, a_flt);
      check_outputs("B", mb, b_st, b_rc, b_en, b_hb, b_srst, b_mute, b_flt);
      rst = r; arm = a; src_kick = k; clear_fault = c; wd_trip = t;
      ma = mdl_step(ma, r, a, k, c, t, 3'b111);
      mb = mdl_step(mb, r, a, k, c, t, 3'b011);
   endtask

   task automatic wait_n(input int n, input bit a);
      for (int i = 0; i < n; i++) cyc(1'b0, a, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic trip(input bit a);
      cyc(1'b0, a, 3'b000, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; src_kick = 3'b000; clear_fault = 1'b0; wd_trip = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();

      // Reset, then startup hold, RUN entry and unmute delay
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      wait_n(30, 1'b1);

      // Kick collection, repeated kicks from one source
      cyc(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b100, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
      wait_n(3, 1'b1);

      // Single trip, recovery, stability period clears the count
      trip(1'b1);
      wait_n(20, 1'b1);
      for (int i = 0; i < 1100; i++)
         cyc(1'b0, 1'b1, (i % 5 == 0) ? 3'b111 : 3'b000, 1'b0, 1'b0);

      // Three close trips into lockout; arm ignored; clear_fault exits
      for (int j = 0; j < 3; j++) begin
         trip(1'b1);
         wait_n(30, 1'b1);
      end
      wait_n(5, 1'b0);
      wait_n(5, 1'b1);
      cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      wait_n(3, 1'b0);

      // Trip together with disarm
      wait_n(30, 1'b1);
      trip(1'b0);
      wait_n(20, 1'b0);

      // Round completing in the trip cycle
      wait_n(30, 1'b1);
      cyc(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b100, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
      wait_n(20, 1'b1);

      // Reset mid-RECOVER, trip ignored in IDLE
      trip(1'b1);
      wait_n(5, 1'b1);
      cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);

      // Reset while locked out
      wait_n(30, 1'b1);
      for (int j = 0; j < 3; j++) begin
         trip(1'b1);
         wait_n(30, 1'b1);
      end
      cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
      wait_n(3, 1'b0);

      // Randomized operation
      for (int i = 0; i < 15000; i++) begin
         bit       r, a, c, t;
         bit [2:0] k;
         r = ($urandom_range(2999) == 0);
         a = ($urandom_range(199) != 0);
         c = ($urandom_range(39) == 0);
         t = ($urandom_range(149) == 0);
         for (int s = 0; s < 3; s++) k[s] = ($urandom_range(3) == 0);
         cyc(r, a, k, c, t);
      end
      cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
